// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller: debounces lane requests, checks vacancy on entry,
// drives both barriers and emits one classed event per completed passage.
module parking_gate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PASS_TIMEOUT    = 64,
  parameter int TO_W            = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       entry_is_uni,
  input  logic       entry_pass,
  input  logic       exit_req,
  input  logic       exit_is_uni,
  input  logic       exit_pass,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_denied,
  output logic [1:0] gate_timeout
);

  // state   | meaning
  // S_IDLE  | gate closed, waiting for a debounced request
  // S_CHECK | one cycle: latch class, sample vacancy
  // S_OPEN  | gate open, waiting for the beam (timeout running)
  // S_PASS  | car in beam, event fires when the beam clears
  // S_CLEAR | gate closed, waiting for the request to drop
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_OPEN, S_PASS, S_CLEAR} state_t;

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PASS_TIMEOUT - 1);

  // Index 0 is the entry lane, index 1 the exit lane.
  logic [1:0]      req_raw, uni_raw, pass_raw, vacant;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [1:0]      req_db_q, pass_q;
  state_t          state_q [2];
  state_t          state_d [2];
  logic [TO_W-1:0] to_cnt_q [2];
  logic [TO_W-1:0] to_cnt_d [2];
  logic [1:0]      uni_q, uni_d;
  logic [1:0]      gate_q, gate_d, done_q, done_d, done_uni_q, done_uni_d;
  logic [1:0]      timeout_q, timeout_d;
  logic            denied_q, denied_d;

  assign req_raw  = {exit_req, entry_req};
  assign uni_raw  = {exit_is_uni, entry_is_uni};
  assign pass_raw = {exit_pass, entry_pass};
  // The exit lane never refuses a car.
  assign vacant   = {1'b1, entry_is_uni ? uni_is_vacated_space : is_vacated_space};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      req_db_q <= '0;
      pass_q   <= '0;
    end else begin
      pass_q <= pass_raw;
      for (int i = 0; i < 2; i++) begin
        if (!req_raw[i]) begin
          db_cnt_q[i] <= '0;
          req_db_q[i] <= 1'b0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          req_db_q[i] <= 1'b1;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= S_IDLE;
        to_cnt_q[i] <= '0;
      end
      uni_q      <= '0;
      gate_q     <= '0;
      done_q     <= '0;
      done_uni_q <= '0;
      timeout_q  <= '0;
      denied_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= state_d[i];
        to_cnt_q[i] <= to_cnt_d[i];
      end
      uni_q      <= uni_d;
      gate_q     <= gate_d;
      done_q     <= done_d;
      done_uni_q <= done_uni_d;
      timeout_q  <= timeout_d;
      denied_q   <= denied_d;
    end
  end

  always_comb begin
    uni_d      = uni_q;
    gate_d     = '0;
    done_d     = '0;
    done_uni_d = '0;
    timeout_d  = '0;
    denied_d   = (state_q[0] == S_CHECK) && !vacant[0];
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      to_cnt_d[i] = '0;
      case (state_q[i])
        S_IDLE: if (req_db_q[i]) state_d[i] = S_CHECK;
        S_CHECK: begin
          uni_d[i]   = uni_raw[i];
          state_d[i] = vacant[i] ? S_OPEN : S_CLEAR;
        end
        S_OPEN: begin
          if (pass_q[i]) begin
            state_d[i] = S_PASS;
          end else if (to_cnt_q[i] == TO_LAST) begin
            timeout_d[i] = 1'b1;
            state_d[i]   = S_CLEAR;
          end else begin
            to_cnt_d[i] = to_cnt_q[i] + 1'b1;
          end
        end
        S_PASS: begin
          if (!pass_q[i]) begin
            done_d[i]     = 1'b1;
            done_uni_d[i] = uni_q[i];
            state_d[i]    = S_CLEAR;
          end
        end
        S_CLEAR: if (!req_db_q[i]) state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
      gate_d[i] = (state_d[i] == S_OPEN) || (state_d[i] == S_PASS);
    end
  end

  assign entry_gate_open    = gate_q[0];
  assign exit_gate_open     = gate_q[1];
  assign car_entered        = done_q[0];
  assign is_uni_car_entered = done_uni_q[0];
  assign car_exited         = done_q[1];
  assign is_uni_car_exited  = done_uni_q[1];
  assign entry_denied       = denied_q;
  assign gate_timeout       = timeout_q;

endmodule
